// File: rtl/blinking_led_multi.sv
// N-channel LED blinker: one shared tick prescaler feeds per-channel interval
// counters. Each channel runs OFF, ON, BLINK or ONESHOT, and sync realigns all channels.
module blinking_led_multi #(
    parameter int N_CH     = 4,
    parameter int W        = 16,
    parameter int TICK_DIV = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_CH*W-1:0] reg_in,
    input  logic [2*N_CH-1:0] mode,
    input  logic              sync,
    output logic [N_CH-1:0]   led,
    output logic [N_CH-1:0]   busy
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    localparam logic [1:0] MODE_OFF     = 2'b00;
    localparam logic [1:0] MODE_ON      = 2'b01;
    localparam logic [1:0] MODE_BLINK   = 2'b10;
    localparam logic [1:0] MODE_ONESHOT = 2'b11;

    logic [PW-1:0] presc_reg;
    logic          tick;

    assign tick = (presc_reg == PRESC_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_reg <= '0;
        end else if (sync || tick) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi = gi + 1) begin : g_ch
            logic [1:0]   mode_q_reg;
            logic [W-1:0] cnt_reg;
            logic         led_reg;
            logic         busy_reg;
            logic [1:0]   mode_i;
            logic [W-1:0] interval;
            logic         at_end;

            assign mode_i   = mode[2*gi +: 2];
            assign interval = reg_in[gi*W +: W];
            // A zero interval counts as already expired so interval-1 never wraps.
            assign at_end   = (interval == '0) || (cnt_reg >= interval - 1'b1);

            always_ff @(posedge clk) begin
                if (reset) begin
                    mode_q_reg <= MODE_OFF;
                    cnt_reg    <= '0;
                    led_reg    <= 1'b0;
                    busy_reg   <= 1'b0;
                end else if (mode_i != mode_q_reg) begin
                    mode_q_reg <= mode_i;
                    cnt_reg    <= '0;
                    case (mode_i)
                        MODE_ON: begin
                            led_reg  <= 1'b1;
                            busy_reg <= 1'b0;
                        end
                        MODE_ONESHOT: begin
                            led_reg  <= (interval != '0);
                            busy_reg <= (interval != '0);
                        end
                        default: begin
                            led_reg  <= 1'b0;
                            busy_reg <= 1'b0;
                        end
                    endcase
                end else if (sync) begin
                    // A busy oneshot restarts simply by clearing its count; led/busy are already high.
                    cnt_reg <= '0;
                    if (mode_q_reg == MODE_BLINK) begin
                        led_reg <= 1'b0;
                    end
                end else if (tick) begin
                    case (mode_q_reg)
                        MODE_BLINK: begin
                            if (interval == '0) begin
                                led_reg <= 1'b0;
                                cnt_reg <= '0;
                            end else if (at_end) begin
                                led_reg <= ~led_reg;
                                cnt_reg <= '0;
                            end else begin
                                cnt_reg <= cnt_reg + 1'b1;
                            end
                        end
                        MODE_ONESHOT: begin
                            if (busy_reg) begin
                                if (at_end) begin
                                    led_reg  <= 1'b0;
                                    busy_reg <= 1'b0;
                                    cnt_reg  <= '0;
                                end else begin
                                    cnt_reg <= cnt_reg + 1'b1;
                                end
                            end
                        end
                        default: begin
                            cnt_reg <= '0;
                        end
                    endcase
                end
            end

            assign led[gi]  = led_reg;
            assign busy[gi] = busy_reg;
        end
    endgenerate

endmodule

// File: tb/tb_blinking_led_multi.sv
// Scoreboard bench for blinking_led_multi: stimulus queues expected led/busy changes
// with their clock edge; a monitor pops one entry per observed output change.
module tb_blinking_led_multi;

    localparam int N_CH     = 4;
    localparam int W        = 16;
    localparam int TICK_DIV = 4;

    logic              clk    = 1'b0;
    logic              reset  = 1'b1;
    logic              sync   = 1'b0;
    logic [N_CH*W-1:0] reg_in = '0;
    logic [2*N_CH-1:0] mode   = '0;
    logic [N_CH-1:0]   led;
    logic [N_CH-1:0]   busy;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic [3:0] led;
        logic [3:0] busy;
    } exp_t;

    exp_t       exp_q[$];
    bit         mon_en = 1'b0;
    logic [7:0] prev   = 8'h00;

    blinking_led_multi #(
        .N_CH    (N_CH),
        .W       (W),
        .TICK_DIV(TICK_DIV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .reg_in(reg_in),
        .mode  (mode),
        .sync  (sync),
        .led   (led),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // cyc = index of the most recent rising edge (first edge is 1)
    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_at(input int c, input logic [3:0] l, input logic [3:0] b);
        exp_t e;
        e.cyc  = c;
        e.led  = l;
        e.busy = b;
        exp_q.push_back(e);
    endtask

    // Inputs driven at the falling edge after edge c are sampled at edge c+1.
    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic set_mode(input int ch, input logic [1:0] m);
        mode[2*ch +: 2] = m;
    endtask

    task automatic set_iv(input int ch, input logic [W-1:0] v);
        reg_in[ch*W +: W] = v;
    endtask

    always @(negedge clk) begin
        logic [7:0] cur;
        exp_t       e;
        if (mon_en) begin
            cur = {led, busy};
            if (cur !== prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change cyc=%0d got led=%b busy=%b, required no change",
                             cyc, led, busy);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || cur !== {e.led, e.busy}) begin
                        errors++;
                        $display("FAIL event cyc=%0d led=%b busy=%b, required cyc=%0d led=%b busy=%b",
                                 cyc, led, busy, e.cyc, e.led, e.busy);
                    end else begin
                        $display("ok   event cyc=%0d led=%b busy=%b", cyc, led, busy);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin
        // Reset sampled on edges 1..3; prescaler 0 after edge 3, so ticks land on edges 7, 11, 15, ...
        wait_until(3);
        reset = 1'b0;
        checks++;
        if ({led, busy} !== 8'h00) begin
            errors++;
            $display("FAIL reset_state got led=%b busy=%b, required led=0000 busy=0000", led, busy);
        end else begin
            $display("ok   reset_state led=%b busy=%b", led, busy);
        end
        prev   = 8'h00;
        mon_en = 1'b1;

        // ch0 BLINK interval 3: entry edge 5, toggles at ticks 15, 27, 39, 51
        wait_until(4);
        expect_at(15, 4'b0001, 4'b0000);
        expect_at(27, 4'b0000, 4'b0000);
        expect_at(39, 4'b0001, 4'b0000);
        expect_at(51, 4'b0000, 4'b0000);
        set_iv(0, 16'd3);
        set_mode(0, 2'b10);
        wait_until(52);
        set_mode(0, 2'b00);

        // ch1 ON with interval 0, ch2 OFF with interval 5, held for 200 cycles
        wait_until(60);
        expect_at(61, 4'b0010, 4'b0000);
        expect_at(262, 4'b0000, 4'b0000);
        set_iv(1, 16'd0);
        set_mode(1, 2'b01);
        set_iv(2, 16'd5);
        set_mode(2, 2'b00);
        wait_until(261);
        set_mode(1, 2'b00);

        // ch3 ONESHOT interval 5: entry 271 (its tick ignored), ends at tick 291;
        // retrigger entry 502, ticks 503..515 count, ends at 519
        wait_until(270);
        expect_at(271, 4'b1000, 4'b1000);
        expect_at(291, 4'b0000, 4'b0000);
        expect_at(502, 4'b1000, 4'b1000);
        expect_at(519, 4'b0000, 4'b0000);
        set_iv(3, 16'd5);
        set_mode(3, 2'b11);
        wait_until(500);
        set_mode(3, 2'b00);
        wait_until(501);
        set_mode(3, 2'b11);
        wait_until(530);
        set_mode(3, 2'b00);

        // ch0 BLINK interval 0 stays low; interval 2 written at edge 642 -> toggles 647, 655, 663
        wait_until(540);
        expect_at(647, 4'b0001, 4'b0000);
        expect_at(655, 4'b0000, 4'b0000);
        expect_at(663, 4'b0001, 4'b0000);
        set_iv(0, 16'd0);
        set_mode(0, 2'b10);
        wait_until(641);
        set_iv(0, 16'd2);

        // ch1 BLINK interval 4 at arbitrary phase, then sync at edge 682
        wait_until(664);
        expect_at(671, 4'b0000, 4'b0000);
        expect_at(679, 4'b0011, 4'b0000);
        expect_at(682, 4'b0000, 4'b0000);
        expect_at(690, 4'b0001, 4'b0000);
        expect_at(698, 4'b0010, 4'b0000);
        expect_at(706, 4'b0011, 4'b0000);
        expect_at(714, 4'b0000, 4'b0000);
        set_iv(1, 16'd4);
        set_mode(1, 2'b10);
        wait_until(681);
        sync = 1'b1;
        wait_until(682);
        sync = 1'b0;
        wait_until(715);
        set_mode(1, 2'b00);

        // ch0 interval 10 reaches cnt=7 at tick 742; interval 3 -> toggle at 746,
        // reset at 749/750, re-entry 751, prescaler restart -> toggle at 762
        wait_until(716);
        expect_at(746, 4'b0001, 4'b0000);
        expect_at(749, 4'b0000, 4'b0000);
        expect_at(762, 4'b0001, 4'b0000);
        expect_at(764, 4'b0000, 4'b0000);
        set_iv(0, 16'd10);
        wait_until(743);
        set_iv(0, 16'd3);
        wait_until(748);
        reset = 1'b1;
        wait_until(750);
        reset = 1'b0;
        wait_until(763);
        set_mode(0, 2'b00);

        wait_until(800);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events got %0d outstanding (next cyc=%0d), required 0",
                     exp_q.size(), exp_q[0].cyc);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
